// File: rtl/dlatch_drive_sequencer.sv
// Conditions an asynchronous data input and drives a gated D latch through a
// timed setup / open / hold window so D is stable while the gate is transparent.
`timescale 1ns/1ps
module dlatch_drive_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYC     = 4,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned OPEN_CYC    = 3,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_d,
    input  logic cap_req,
    input  logic ovr_clr,
    output logic deb_d,
    output logic latch_d,
    output logic latch_en,
    output logic busy,
    output logic done,
    output logic req_overrun
);

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;
    logic [CNT_W-1:0]       deb_cnt;
    logic [CNT_W-1:0]       ph_cnt;

    assign s_d = sync_q[SYNC_STAGES-1];

    // Metastability synchroniser for the asynchronous source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_d};
        end
    end

    // deb_d follows s_d only after DEB_CYC consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_d   <= 1'b0;
            deb_cnt <= '0;
        end else if (s_d == deb_d) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_d   <= s_d;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
        end
    end

    // Window sequencer; latch_d only moves on IDLE->SETUP, latch_en only on
    // SETUP->OPEN and OPEN->HOLD, so the two never change on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ph_cnt      <= '0;
            latch_d     <= 1'b0;
            latch_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            req_overrun <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy && cap_req) begin
                req_overrun <= 1'b1;
            end else if (ovr_clr) begin
                req_overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cap_req) begin
                        latch_d <= deb_d;
                        ph_cnt  <= '0;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (ph_cnt == SETUP_LAST) begin
                        latch_en <= 1'b1;
                        ph_cnt   <= '0;
                        state    <= OPEN;
                    end else begin
                        ph_cnt <= ph_cnt + CNT_W'(1);
                    end
                end
                OPEN: begin
                    if (ph_cnt == OPEN_LAST) begin
                        latch_en <= 1'b0;
                        ph_cnt   <= '0;
                        state    <= HOLD;
                    end else begin
                        ph_cnt <= ph_cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (ph_cnt == HOLD_LAST) begin
                        ph_cnt <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        ph_cnt <= ph_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
